uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ_p, default 4, SHALL set the number of byte-stream requesters (2..8).
REQ-002 Parameter TIMEOUT_p, default 1024, SHALL set the idle-cycle limit before a locked grant is revoked (1..65535).
REQ-003 clk  in  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 i_req_en  in  NUM_REQ_p  SHALL be the per-requester enable mask.
REQ-006 i_req_valid  in  NUM_REQ_p  SHALL be the per-requester byte-valid flags.
REQ-007 i_req_data  in  NUM_REQ_p*8  SHALL be the packed bytes, requester k at bits [8k+7:8k].
REQ-008 i_req_last  in  NUM_REQ_p  SHALL mark the final byte of a requester's message.
REQ-009 o_req_ready  out  NUM_REQ_p  SHALL be the per-requester byte-accept flags.
REQ-010 i_tx_fifo_full  in  1  SHALL be the UART TX FIFO full flag.
REQ-011 o_tx_fifo_wr_en  out  1  SHALL be the UART TX FIFO write enable.
REQ-012 o_tx_fifo_data  out  8  SHALL be the UART TX FIFO write data.
REQ-013 o_grant_id  out  $clog2(NUM_REQ_p)  SHALL be the index of the current/last granted requester.
REQ-014 o_busy  out  1  SHALL be high while a grant is locked.
REQ-015 o_timeout  out  1  SHALL pulse one cycle when a grant is revoked by timeout.

Function
REQ-016 FSM states SHALL be IDLE and LOCK only.
REQ-017 In IDLE, the eligible set SHALL be i_req_valid & i_req_en; if non-empty, the block SHALL select the first eligible index strictly after the last-granted pointer, wrapping NUM_REQ_p-1 -> 0, register it into o_grant_id, and enter LOCK next cycle.
REQ-018 In IDLE, o_req_ready SHALL be all zero and o_tx_fifo_wr_en low.
REQ-019 In LOCK, o_req_ready[g] SHALL equal !i_tx_fifo_full for granted index g, all other bits zero (combinational).
REQ-020 A transfer SHALL occur when i_req_valid[g] & o_req_ready[g]; then o_tx_fifo_wr_en = 1 and o_tx_fifo_data = byte g in the same cycle.
REQ-021 A transfer with i_req_last[g] = 1 SHALL return FSM to IDLE and update the last-granted pointer to g.
REQ-022 Minimum gap between a last byte and the next grant's first byte SHALL be one idle cycle (IDLE arbitration cycle).
REQ-023 Clearing i_req_en[g] during LOCK SHALL NOT abort the current message; the mask affects arbitration only.
REQ-024 Idle counter (16 bits) SHALL increment each LOCK cycle with i_req_valid[g] = 0, clear on any transfer or LOCK entry, and SHALL NOT increment while stalled by i_tx_fifo_full with valid high.
REQ-025 When the idle counter reaches TIMEOUT_p, FSM SHALL return to IDLE, pulse o_timeout for one cycle, update the last-granted pointer to g, and keep o_grant_id = g.
REQ-026 Full and last in the same cycle SHALL produce no transfer; FSM remains in LOCK.
REQ-027 o_busy SHALL equal (state == LOCK).

Reset
REQ-028 On rst, state SHALL be IDLE, last-granted pointer NUM_REQ_p-1 (so requester 0 wins first), o_grant_id 0, idle counter 0, o_timeout 0, o_busy 0, o_req_ready 0, o_tx_fifo_wr_en 0, o_tx_fifo_data 0.
REQ-029 Reset asserted mid-message SHALL abandon the message immediately; no partial-byte write SHALL occur in the reset cycle.

Structure
REQ-030 The FSM state enum and idle-counter width constant SHALL live in shared package uart_pkg.
REQ-031 Round-robin selection SHALL be a combinational sub-module uart_rr_pick (inputs eligible mask, pointer; outputs valid, index).

Verification
REQ-032 Reset then req0 sends 3 bytes 0x41,0x42,0x43 (last on third) -> three wr_en pulses with those bytes, o_grant_id 0, o_busy drops after third.
REQ-033 req1 and req2 valid simultaneously, pointer after reset -> req0 idle: req1 message fully written before any req2 byte; then req2 granted.
REQ-034 i_tx_fifo_full held 5 cycles mid-message with valid high -> no wr_en, ready low, no timeout, resumes with correct next byte.
REQ-035 TIMEOUT_p = 8, granted req3 drops valid after first byte -> o_timeout pulses on eighth idle cycle, FSM IDLE, next grant goes to req0.
REQ-036 i_req_en[2] = 0 with req2 valid and req3 valid -> req3 granted, req2 never ready; clearing i_req_en[3] mid-message still completes req3's message.
REQ-037 rst asserted while req0 mid-message -> wr_en low that cycle, after release req0 re-arbitrated from IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX byte-stream arbiter.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  localparam int IDLE_CNT_W = 16;

  // Index width for a requester count, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first eligible index strictly after i_ptr, wrapping.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_p = 4,
  parameter int IW_p  = idx_width(NUM_p)
) (
  input  logic [NUM_p-1:0] i_eligible,
  input  logic [IW_p-1:0]  i_ptr,
  output logic             o_valid,
  output logic [IW_p-1:0]  o_idx
);

  int w_k;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_k     = 0;
    // Offset 1 first so the requester just served has lowest priority.
    for (int i = 1; i <= NUM_p; i++) begin
      w_k = int'(i_ptr) + i;
      if (w_k >= NUM_p) w_k = w_k - NUM_p;
      if (!o_valid && i_eligible[w_k]) begin
        o_valid = 1'b1;
        o_idx   = w_k[IW_p-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter granting whole byte messages from several requesters into one UART TX FIFO.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ_p = 4,
  parameter int TIMEOUT_p = 1024,
  localparam int IW       = idx_width(NUM_REQ_p)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ_p-1:0]   i_req_en,
  input  logic [NUM_REQ_p-1:0]   i_req_valid,
  input  logic [NUM_REQ_p*8-1:0] i_req_data,
  input  logic [NUM_REQ_p-1:0]   i_req_last,
  output logic [NUM_REQ_p-1:0]   o_req_ready,
  input  logic                   i_tx_fifo_full,
  output logic                   o_tx_fifo_wr_en,
  output logic [7:0]             o_tx_fifo_data,
  output logic [IW-1:0]          o_grant_id,
  output logic                   o_busy,
  output logic                   o_timeout
);

  localparam logic [IDLE_CNT_W-1:0] TMO_LAST = IDLE_CNT_W'(TIMEOUT_p - 1);

  arb_state_t            r_state;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_grant_id;
  logic [IDLE_CNT_W-1:0] r_idle_cnt;
  logic                  r_timeout;

  logic [NUM_REQ_p-1:0]  w_eligible;
  logic                  w_pick_valid;
  logic [IW-1:0]         w_pick_idx;
  logic                  w_gnt_valid;
  logic                  w_gnt_last;
  logic [7:0]            w_gnt_data;
  logic                  w_lock;
  logic                  w_xfer;

  assign w_eligible = i_req_valid & i_req_en;

  uart_rr_pick #(
    .NUM_p (NUM_REQ_p),
    .IW_p  (IW)
  ) u_pick (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_valid    (w_pick_valid),
    .o_idx      (w_pick_idx)
  );

  // The enable mask is deliberately absent here: it only gates arbitration.
  assign w_lock      = (r_state == ST_LOCK);
  assign w_gnt_valid = i_req_valid[r_grant_id];
  assign w_gnt_last  = i_req_last[r_grant_id];
  assign w_gnt_data  = i_req_data[{r_grant_id, 3'b000} +: 8];
  assign w_xfer      = w_lock && w_gnt_valid && !i_tx_fifo_full;

  assign o_req_ready     = (w_lock && !i_tx_fifo_full) ? (NUM_REQ_p'(1) << r_grant_id) : '0;
  assign o_tx_fifo_wr_en = w_xfer;
  assign o_tx_fifo_data  = w_xfer ? w_gnt_data : 8'h00;
  assign o_grant_id      = r_grant_id;
  assign o_busy          = w_lock;
  assign o_timeout       = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= IW'(NUM_REQ_p - 1);
      r_grant_id <= '0;
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_state    <= ST_LOCK;
            r_grant_id <= w_pick_idx;
            r_idle_cnt <= '0;
          end
        end
        ST_LOCK: begin
          if (w_xfer) begin
            r_idle_cnt <= '0;
            if (w_gnt_last) begin
              r_state <= ST_IDLE;
              r_ptr   <= r_grant_id;
            end
          end else if (!w_gnt_valid) begin
            // A FIFO stall with valid high is not idleness; only a silent owner ages.
            if (r_idle_cnt == TMO_LAST) begin
              r_state    <= ST_IDLE;
              r_ptr      <= r_grant_id;
              r_timeout  <= 1'b1;
              r_idle_cnt <= '0;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed messages, FIFO stall, timeout, masking and reset abort.
module tb_uart_tx_arb;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  en = '1;
  logic [N-1:0]  v = '0;
  logic [N*8-1:0] dat = '0;
  logic [N-1:0]  l = '0;
  logic [N-1:0]  o_req_ready;
  logic          full = 1'b0;
  logic          o_tx_fifo_wr_en;
  logic [7:0]    o_tx_fifo_data;
  logic [1:0]    o_grant_id;
  logic          o_busy;
  logic          o_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] sb_q[$];
  bit watch2 = 1'b0;
  int bad2 = 0;

  uart_tx_arb #(.NUM_REQ_p(N), .TIMEOUT_p(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req_en        (en),
    .i_req_valid     (v),
    .i_req_data      (dat),
    .i_req_last      (l),
    .o_req_ready     (o_req_ready),
    .i_tx_fifo_full  (full),
    .o_tx_fifo_wr_en (o_tx_fifo_wr_en),
    .o_tx_fifo_data  (o_tx_fifo_data),
    .o_grant_id      (o_grant_id),
    .o_busy          (o_busy),
    .o_timeout       (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every FIFO write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (o_tx_fifo_wr_en) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {24'h0, o_tx_fifo_data}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = sb_q.pop_front();
        chk("wr_data", {24'h0, o_tx_fifo_data}, {24'h0, e[7:0]});
        chk("wr_gid", {30'h0, o_grant_id}, {30'h0, e[9:8]});
      end
    end
  end

  always @(negedge clk) begin
    if (watch2 && o_req_ready[2]) bad2++;
  end

  task automatic expect_msg(input int k, input int n, input logic [31:0] bs);
    for (int i = 0; i < n; i++) sb_q.push_back({k[1:0], bs[8*i +: 8]});
  endtask

  task automatic wait_ready(input int k);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!o_req_ready[k] && w < 200);
    if (w >= 200) chk("ready_timeout", 32'(k), 32'hFFFF_FFFF);
  endtask

  task automatic send_msg(input int k, input int n, input logic [31:0] bs);
    for (int i = 0; i < n; i++) begin
      v[k] = 1'b1;
      dat[8*k +: 8] = bs[8*i +: 8];
      l[k] = (i == n - 1);
      wait_ready(k);
      @(posedge clk); #1;
    end
    v[k] = 1'b0;
    l[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int w, bad;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, o_busy}, 0);
    chk("rst_gid", {30'h0, o_grant_id}, 0);
    chk("rst_ready", {28'h0, o_req_ready}, 0);
    chk("rst_wr_en", {31'h0, o_tx_fifo_wr_en}, 0);
    chk("rst_data", {24'h0, o_tx_fifo_data}, 0);
    chk("rst_timeout", {31'h0, o_timeout}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single three-byte message from requester 0.
    expect_msg(0, 3, 32'h00_43_42_41);
    send_msg(0, 3, 32'h00_43_42_41);
    @(negedge clk);
    chk("t1_busy_drop", {31'h0, o_busy}, 0);
    chk("t1_gid", {30'h0, o_grant_id}, 0);

    // Requesters 1 and 2 together: 1 must finish completely before 2 starts.
    expect_msg(1, 3, 32'h00_13_12_11);
    expect_msg(2, 2, 32'h00_00_22_21);
    fork
      send_msg(1, 3, 32'h00_13_12_11);
      send_msg(2, 2, 32'h00_00_22_21);
    join
    @(negedge clk);
    chk("t2_gid", {30'h0, o_grant_id}, 2);

    // FIFO stall with the last byte pending: nothing moves, grant holds.
    expect_msg(3, 2, 32'h00_00_32_31);
    v[3] = 1'b1; dat[31:24] = 8'h31; l[3] = 1'b0;
    wait_ready(3);
    @(posedge clk); #1;
    dat[31:24] = 8'h32; l[3] = 1'b1; full = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_req_ready[3] || o_tx_fifo_wr_en || o_timeout || !o_busy) bad++;
    end
    chk("t3_stall_clean", 32'(bad), 0);
    @(posedge clk); #1;
    full = 1'b0;
    wait_ready(3);
    @(posedge clk); #1;
    v[3] = 1'b0; l[3] = 1'b0;
    @(negedge clk);
    chk("t3_busy_drop", {31'h0, o_busy}, 0);

    // Requester 3 goes silent after one byte: revoked after 8 idle cycles.
    expect_msg(3, 1, 32'h0000_0035);
    v[3] = 1'b1; dat[31:24] = 8'h35; l[3] = 1'b0;
    wait_ready(3);
    @(posedge clk); #1;
    v[3] = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!o_timeout && w < 40);
    chk("t4_timeout_cycle", 32'(w), 9);
    chk("t4_idle_after", {31'h0, o_busy}, 0);
    chk("t4_gid_kept", {30'h0, o_grant_id}, 3);
    @(negedge clk);
    chk("t4_pulse_width", {31'h0, o_timeout}, 0);
    expect_msg(0, 1, 32'h0000_0051);
    expect_msg(3, 1, 32'h0000_0036);
    fork
      send_msg(0, 1, 32'h0000_0051);
      send_msg(3, 1, 32'h0000_0036);
    join

    // Masked requester 2 is skipped; dropping 3's enable mid-message is harmless.
    en[2] = 1'b0;
    v[2] = 1'b1; dat[23:16] = 8'h27; l[2] = 1'b1;
    watch2 = 1'b1;
    expect_msg(3, 3, 32'h00_73_72_71);
    fork
      send_msg(3, 3, 32'h00_73_72_71);
      begin
        int c;
        c = 0;
        do begin
          @(negedge clk);
          c++;
        end while (!o_tx_fifo_wr_en && c < 100);
        @(posedge clk); #1;
        en[3] = 1'b0;
      end
    join
    @(negedge clk);
    watch2 = 1'b0;
    chk("t5_req2_never_ready", 32'(bad2), 0);
    chk("t5_busy_drop", {31'h0, o_busy}, 0);
    chk("t5_gid", {30'h0, o_grant_id}, 3);
    v[2] = 1'b0; l[2] = 1'b0;
    en = '1;
    @(posedge clk); #1;

    // Reset during requester 0's message kills the pending write immediately.
    expect_msg(0, 1, 32'h0000_0061);
    v[0] = 1'b1; dat[7:0] = 8'h61; l[0] = 1'b0;
    wait_ready(0);
    @(posedge clk); #1;
    dat[7:0] = 8'h62;
    #1;
    rst = 1'b1;
    #1;
    chk("t6_wr_en_in_rst", {31'h0, o_tx_fifo_wr_en}, 0);
    chk("t6_busy_in_rst", {31'h0, o_busy}, 0);
    chk("t6_ready_in_rst", {28'h0, o_req_ready}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_msg(0, 2, 32'h0000_6362);
    send_msg(0, 2, 32'h0000_6362);
    @(negedge clk);
    chk("t6_gid", {30'h0, o_grant_id}, 0);
    chk("t6_busy_drop", {31'h0, o_busy}, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
